// File: rtl/sata_oob_decoder.sv
// SATA OOB receive decoder: times bursts/gaps on rxelecidle and pulses cominit/comwake.
// Optional macro SATA_OOB_DECODER_SYNC_EN adds a 2-flop synchroniser for an asynchronous rxelecidle.
module sata_oob_decoder #(
  parameter int CLKFREQ = 100_000,
  parameter int AMOUNT  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rxelecidle,
  output logic cominit,
  output logic comwake
);

  localparam int WMIN  = (55 * CLKFREQ + 999_999) / 1_000_000;
  localparam int IMIN  = (175 * CLKFREQ + 999_999) / 1_000_000;
  localparam int IMAX  = (525 * CLKFREQ) / 1_000_000;
  localparam int BMAX  = (175 * CLKFREQ) / 1_000_000;
  localparam int GAP_W = $clog2(IMAX + 2);
  localparam int BUR_W = $clog2(BMAX + 2);
  localparam int SEQ_W = $clog2(AMOUNT + 1);

  localparam logic [GAP_W-1:0] WMIN_G = GAP_W'(WMIN);
  localparam logic [GAP_W-1:0] IMIN_G = GAP_W'(IMIN);
  localparam logic [GAP_W-1:0] IMAX_G = GAP_W'(IMAX);
  localparam logic [GAP_W-1:0] GSAT_G = GAP_W'(IMAX + 1);
  localparam logic [BUR_W-1:0] BMAX_B = BUR_W'(BMAX);
  localparam logic [BUR_W-1:0] BSAT_B = BUR_W'(BMAX + 1);
  localparam logic [SEQ_W-1:0] DET_S  = SEQ_W'(AMOUNT - 1);

  typedef enum logic [1:0] {ST_WAIT, ST_QUIET, ST_BURST, ST_GAP} state_t;
  typedef enum logic [1:0] {GAP_INVALID, GAP_WAKE, GAP_INIT} gap_t;

  function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] n);
    return (n >= GSAT_G) ? GSAT_G : n + GAP_W'(1);
  endfunction

  function automatic logic [BUR_W-1:0] burst_inc(input logic [BUR_W-1:0] n);
    return (n >= BSAT_B) ? BSAT_B : n + BUR_W'(1);
  endfunction

  function automatic gap_t classify(input logic [GAP_W-1:0] n);
    if (n >= WMIN_G && n < IMIN_G)       return GAP_WAKE;
    else if (n >= IMIN_G && n <= IMAX_G) return GAP_INIT;
    else                                 return GAP_INVALID;
  endfunction

  logic idle_raw;
  logic i_s_p0;

  // Stage p0: optional synchroniser, then the input register.
`ifdef SATA_OOB_DECODER_SYNC_EN
  logic sync_a_p0;
  logic sync_b_p0;
  always_ff @(posedge clk) begin
    sync_a_p0 <= rxelecidle;
    sync_b_p0 <= sync_a_p0;
  end
  assign idle_raw = sync_b_p0;
`else
  assign idle_raw = rxelecidle;
`endif

  always_ff @(posedge clk) begin
    if (reset) i_s_p0 <= 1'b1;
    else       i_s_p0 <= idle_raw;
  end

  state_t           state_p1;
  logic [GAP_W-1:0] gap_cnt_p1;
  logic [BUR_W-1:0] burst_cnt_p1;
  gap_t             seq_type_p1;
  logic [SEQ_W-1:0] seq_cnt_p1;
  gap_t             gap_class;
  logic [SEQ_W-1:0] seq_inc;

  assign gap_class = classify(gap_cnt_p1);
  assign seq_inc   = (gap_class == seq_type_p1) ? seq_cnt_p1 + SEQ_W'(1) : SEQ_W'(1);

  // Stage p1: burst/gap FSM, sequence tracking and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= ST_WAIT;
      gap_cnt_p1   <= '0;
      burst_cnt_p1 <= '0;
      seq_type_p1  <= GAP_INVALID;
      seq_cnt_p1   <= '0;
      cominit      <= 1'b0;
      comwake      <= 1'b0;
    end else begin
      cominit <= 1'b0;
      comwake <= 1'b0;
      case (state_p1)
        ST_WAIT: if (i_s_p0) state_p1 <= ST_QUIET;
        ST_QUIET: begin
          if (!i_s_p0) begin
            state_p1     <= ST_BURST;
            burst_cnt_p1 <= BUR_W'(1);
          end
        end
        ST_BURST: begin
          if (burst_cnt_p1 > BMAX_B) begin
            // Too long for an OOB burst: this is normal traffic.
            state_p1    <= ST_WAIT;
            seq_cnt_p1  <= '0;
            seq_type_p1 <= GAP_INVALID;
          end else if (i_s_p0) begin
            state_p1   <= ST_GAP;
            gap_cnt_p1 <= GAP_W'(1);
          end else begin
            burst_cnt_p1 <= burst_inc(burst_cnt_p1);
          end
        end
        ST_GAP: begin
          if (!i_s_p0) begin
            state_p1     <= ST_BURST;
            burst_cnt_p1 <= BUR_W'(1);
            if (gap_class == GAP_INVALID) begin
              seq_cnt_p1 <= '0;
            end else if (seq_inc == DET_S) begin
              cominit     <= (gap_class == GAP_INIT);
              comwake     <= (gap_class == GAP_WAKE);
              seq_cnt_p1  <= '0;
              seq_type_p1 <= GAP_INVALID;
            end else begin
              seq_cnt_p1  <= seq_inc;
              seq_type_p1 <= gap_class;
            end
          end else if (gap_cnt_p1 > IMAX_G) begin
            state_p1    <= ST_QUIET;
            seq_cnt_p1  <= '0;
            seq_type_p1 <= GAP_INVALID;
          end else begin
            gap_cnt_p1 <= gap_inc(gap_cnt_p1);
          end
        end
        default: state_p1 <= ST_WAIT;
      endcase
    end
  end

endmodule
